// File: rtl/xo_pkg.sv
// Shared constants and types for the XO-format integer instruction sequencer.
package xo_pkg;

  localparam logic [5:0] PO_XO     = 6'd31;
  localparam logic [8:0] XO_ADD    = 9'd266;
  localparam logic [8:0] XO_SUBF   = 9'd40;
  localparam logic [8:0] XO_NEG    = 9'd104;
  localparam logic [8:0] XO_MULLD  = 9'd233;

  typedef enum logic [1:0] {
    AluAdd  = 2'd0,
    AluSubf = 2'd1,
    AluNeg  = 2'd2,
    AluMul  = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWb,
    StErr
  } state_e;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       oe;
    logic       rc;
    alu_op_e    op;
    logic       is_mul;
  } dec_t;

endpackage

// File: rtl/xo_decode.sv
// Combinational field extraction and legality check for an XO-format instruction word.
module xo_decode
  import xo_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o,
  output logic        legal_o
);

  logic [5:0] po;
  logic [8:0] xo;

  always_comb begin
    po            = instr_i[31:26];
    xo            = instr_i[9:1];
    dec_o.rt      = instr_i[25:21];
    dec_o.ra      = instr_i[20:16];
    dec_o.rb      = instr_i[15:11];
    dec_o.oe      = instr_i[10];
    dec_o.rc      = instr_i[0];
    dec_o.op      = AluAdd;
    dec_o.is_mul  = 1'b0;
    legal_o       = 1'b0;

    case (xo)
      XO_ADD: begin
        dec_o.op = AluAdd;
        legal_o  = 1'b1;
      end
      XO_SUBF: begin
        dec_o.op = AluSubf;
        legal_o  = 1'b1;
      end
      XO_NEG: begin
        dec_o.op = AluNeg;
        legal_o  = 1'b1;
      end
      XO_MULLD: begin
        dec_o.op     = AluMul;
        dec_o.is_mul = 1'b1;
        legal_o      = 1'b1;
      end
      default: ;
    endcase

    if (po != PO_XO) legal_o = 1'b0;
  end

endmodule

// File: rtl/xo_exec_ctrl.sv
// Sequencer for XO-format integer ops: fetch operands, wait out ALU latency, write back
// and maintain XER[OV,SO] and CR0.
module xo_exec_ctrl
  import xo_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        rf_rd_en,
  output logic [4:0]  rf_ra_addr,
  output logic [4:0]  rf_rb_addr,
  input  logic [63:0] rf_ra_data,
  input  logic [63:0] rf_rb_data,
  output logic [1:0]  alu_op,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_result,
  input  logic        alu_ov,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [63:0] rf_wr_data,
  output logic        xer_ov,
  output logic        xer_so,
  output logic [3:0]  cr0,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned MaxLat = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  dec_t dec;
  logic legal;

  xo_decode u_decode (
    .instr_i (instr),
    .dec_o   (dec),
    .legal_o (legal)
  );

  state_e          state_q, state_d;
  dec_t            dec_q, dec_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            first_q, first_d;
  logic [63:0]     a_q, a_d, b_q, b_d;
  logic [63:0]     res_q, res_d;
  logic            ov_q, ov_d;
  logic            xer_ov_q, xer_ov_d, xer_so_q, xer_so_d;
  logic [3:0]      cr0_q, cr0_d;

  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    cnt_d       = cnt_q;
    first_d     = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    ov_d        = ov_q;
    xer_ov_d    = xer_ov_q;
    xer_so_d    = xer_so_q;
    cr0_d       = cr0_q;
    instr_ready = 1'b0;
    rf_rd_en    = 1'b0;
    rf_wr_en    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          dec_d   = dec;
          state_d = legal ? StRead : StErr;
        end
      end
      StRead: begin
        rf_rd_en = 1'b1;
        first_d  = 1'b1;
        cnt_d    = dec_q.is_mul ? CntW'(MUL_LAT - 1) : CntW'(ALU_LAT - 1);
        state_d  = StExec;
      end
      StExec: begin
        // Register-file data is only valid in the first EXEC cycle; hold it afterwards.
        if (first_q) begin
          a_d = rf_ra_data;
          b_d = rf_rb_data;
        end
        if (cnt_q == '0) begin
          res_d   = alu_result;
          ov_d    = alu_ov;
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWb: begin
        rf_wr_en = 1'b1;
        done     = 1'b1;
        if (dec_q.oe) begin
          xer_ov_d = ov_q;
          xer_so_d = xer_so_q | ov_q;
        end
        if (dec_q.rc) begin
          cr0_d = {res_q[63], ~res_q[63] & (res_q != '0), res_q == '0, xer_so_d};
        end
        state_d = StIdle;
      end
      StErr: begin
        illegal = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dec_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ov_q     <= 1'b0;
      xer_ov_q <= 1'b0;
      xer_so_q <= 1'b0;
      cr0_q    <= '0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      ov_q     <= ov_d;
      xer_ov_q <= xer_ov_d;
      xer_so_q <= xer_so_d;
      cr0_q    <= cr0_d;
    end
  end

  // Feed the ALU straight from the register file in the first EXEC cycle so ALU_LAT=1 works.
  assign alu_a      = first_q ? rf_ra_data : a_q;
  assign alu_b      = first_q ? rf_rb_data : b_q;
  assign alu_op     = dec_q.op;
  assign rf_ra_addr = dec_q.ra;
  assign rf_rb_addr = dec_q.rb;
  assign rf_wr_addr = dec_q.rt;
  assign rf_wr_data = res_q;
  assign xer_ov     = xer_ov_q;
  assign xer_so     = xer_so_q;
  assign cr0        = cr0_q;

endmodule

// File: tb/tb_xo_exec_ctrl.sv
// Directed and randomized bench for xo_exec_ctrl against a wide-arithmetic reference model.
module tb_xo_exec_ctrl;

  localparam int unsigned AluLat = 1;
  localparam int unsigned MulLat = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        rf_rd_en;
  logic [4:0]  rf_ra_addr, rf_rb_addr;
  logic [63:0] rf_ra_data = '0;
  logic [63:0] rf_rb_data = '0;
  logic [1:0]  alu_op;
  logic [63:0] alu_a, alu_b;
  logic [63:0] alu_result;
  logic        alu_ov;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic        xer_ov, xer_so;
  logic [3:0]  cr0;
  logic        done, illegal;

  always #5 clk = ~clk;

  xo_exec_ctrl #(
    .ALU_LAT (AluLat),
    .MUL_LAT (MulLat)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_rd_en    (rf_rd_en),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_ra_data  (rf_ra_data),
    .rf_rb_data  (rf_rb_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_ov      (alu_ov),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .xer_ov      (xer_ov),
    .xer_so      (xer_so),
    .cr0         (cr0),
    .done        (done),
    .illegal     (illegal)
  );

  // Register file owned by the bench; it holds the model's architectural values.
  logic [63:0] regs [32];

  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_ra_data <= regs[rf_ra_addr];
      rf_rb_data <= regs[rf_rb_addr];
    end
  end

  // Environment ALU (the external datapath), overflow from sign-bit rules.
  logic signed [127:0] mul_full;
  always_comb begin
    alu_result = '0;
    alu_ov     = 1'b0;
    mul_full   = '0;
    case (alu_op)
      2'd0: begin
        alu_result = alu_a + alu_b;
        alu_ov = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      2'd1: begin
        alu_result = alu_b - alu_a;
        alu_ov = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_b[63]);
      end
      2'd2: begin
        alu_result = -alu_a;
        alu_ov = (alu_a == 64'h8000_0000_0000_0000);
      end
      default: begin
        mul_full   = $signed(alu_a) * $signed(alu_b);
        alu_result = mul_full[63:0];
        alu_ov = !((&mul_full[127:63]) || (~|mul_full[127:63]));
      end
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic m_ov = 1'b0;
  logic m_so = 1'b0;
  logic [3:0] m_cr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] po, input logic [4:0] rt,
                                     input logic [4:0] ra, input logic [4:0] rb,
                                     input logic oe, input logic [8:0] xo, input logic rc);
    return {po, rt, ra, rb, oe, xo, rc};
  endfunction

  function automatic logic is_legal(input logic [31:0] iw);
    logic [8:0] xo;
    xo = iw[9:1];
    return (iw[31:26] == 6'd31) &&
           (xo == 9'd266 || xo == 9'd40 || xo == 9'd104 || xo == 9'd233);
  endfunction

  function automatic logic [1:0] exp_op(input logic [8:0] xo);
    case (xo)
      9'd266:  return 2'd0;
      9'd40:   return 2'd1;
      9'd104:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Reference: exact 128-bit signed arithmetic, overflow when the result does not fit 64 bits.
  task automatic ref_op(input logic [8:0] xo, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output logic ov);
    longint sa, sb, sr;
    logic signed [127:0] wa, wb, w, wr;
    sa = a;
    sb = b;
    wa = sa;
    wb = sb;
    case (xo)
      9'd266:  w = wa + wb;
      9'd40:   w = wb - wa;
      9'd104:  w = -wa;
      default: w = wa * wb;
    endcase
    r  = w[63:0];
    sr = r;
    wr = sr;
    ov = (w != wr);
  endtask

  task automatic model_wb(input logic [31:0] iw, input logic [63:0] r, input logic ov);
    regs[iw[25:21]] = r;
    if (iw[10]) begin
      m_ov = ov;
      m_so = m_so | ov;
    end
    if (iw[0]) m_cr = {r[63], !r[63] && (r != '0), r == '0, m_so};
  endtask

  // Issue one instruction from IDLE and check it cycle by cycle until it retires.
  task automatic run(input logic [31:0] iw);
    logic [63:0] r;
    logic        ov;
    int          lat;
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr       = iw;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom;
    if (!is_legal(iw)) begin
      chk("illegal_pulse", illegal, 1);
      chk("err_no_rd", rf_rd_en, 0);
      chk("err_no_done", done, 0);
      chk("err_busy", instr_ready, 0);
      @(negedge clk);
      chk("err_ready", instr_ready, 1);
      chk("err_one_cycle", illegal, 0);
      chk("err_no_wr", rf_wr_en, 0);
      chk("err_xer", {xer_so, xer_ov}, {m_so, m_ov});
      chk("err_cr0", cr0, m_cr);
    end else begin
      ref_op(iw[9:1], regs[iw[20:16]], regs[iw[15:11]], r, ov);
      lat = (iw[9:1] == 9'd233) ? MulLat : AluLat;
      chk("read_en", rf_rd_en, 1);
      chk("read_ra", rf_ra_addr, iw[20:16]);
      chk("read_rb", rf_rb_addr, iw[15:11]);
      chk("read_busy", instr_ready, 0);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        chk("exec_busy", instr_ready, 0);
        chk("exec_no_wr", rf_wr_en, 0);
        chk("exec_no_done", done, 0);
        chk("exec_alu_a", alu_a, regs[iw[20:16]]);
        chk("exec_alu_b", alu_b, regs[iw[15:11]]);
        chk("exec_alu_op", alu_op, exp_op(iw[9:1]));
      end
      @(negedge clk);
      chk("wb_done", done, 1);
      chk("wb_wr_en", rf_wr_en, 1);
      chk("wb_addr", rf_wr_addr, iw[25:21]);
      chk("wb_data", rf_wr_data, r);
      chk("wb_not_illegal", illegal, 0);
      chk("wb_busy", instr_ready, 0);
      model_wb(iw, r, ov);
      @(negedge clk);
      chk("post_xer_ov", xer_ov, m_ov);
      chk("post_xer_so", xer_so, m_so);
      chk("post_cr0", cr0, m_cr);
      chk("post_done_low", done, 0);
      chk("post_ready", instr_ready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iw, iwb;
    logic [63:0] ra_exp, rb_exp;
    logic        ova, ovb;
    logic [8:0]  xo_tab [4];

    xo_tab[0] = 9'd266;
    xo_tab[1] = 9'd40;
    xo_tab[2] = 9'd104;
    xo_tab[3] = 9'd233;
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_rd_en", rf_rd_en, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_xer", {xer_so, xer_ov}, 0);
    chk("rst_cr0", cr0, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_wr_data", rf_wr_data, 0);
    rst_n = 1'b1;

    // add R7,R2,R6
    regs[2] = 64'd5;
    regs[6] = 64'd10;
    run(mk(6'd31, 5'd7, 5'd2, 5'd6, 1'b0, 9'd266, 1'b0));

    // subf. both signs
    regs[3] = 64'd4;
    regs[9] = 64'd20;
    run(mk(6'd31, 5'd7, 5'd3, 5'd9, 1'b0, 9'd40, 1'b1));
    regs[3] = 64'd20;
    regs[9] = 64'd4;
    run(mk(6'd31, 5'd7, 5'd3, 5'd9, 1'b0, 9'd40, 1'b1));

    // addo. overflow, then addo without overflow keeps SO
    regs[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    regs[5] = 64'd1;
    run(mk(6'd31, 5'd8, 5'd4, 5'd5, 1'b1, 9'd266, 1'b1));
    regs[4] = 64'd1;
    regs[5] = 64'd1;
    run(mk(6'd31, 5'd8, 5'd4, 5'd5, 1'b1, 9'd266, 1'b0));

    // Illegal opcodes
    run(mk(6'd14, 5'd1, 5'd2, 5'd3, 1'b1, 9'd266, 1'b1));
    run(mk(6'd31, 5'd1, 5'd2, 5'd3, 1'b1, 9'd7, 1'b1));

    // mulld, RT aliasing RA, and register 0 as an ordinary register
    regs[2] = -64'd3;
    regs[3] = 64'd7;
    run(mk(6'd31, 5'd1, 5'd2, 5'd3, 1'b0, 9'd233, 1'b0));
    regs[0] = 64'd9;
    run(mk(6'd31, 5'd0, 5'd0, 5'd0, 1'b1, 9'd104, 1'b1));

    // Reset in cycle 3 of a mulld aborts without write-back
    regs[2] = -64'd3;
    regs[3] = 64'd7;
    @(negedge clk);
    instr       = mk(6'd31, 5'd1, 5'd2, 5'd3, 1'b1, 9'd233, 1'b1);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", instr_ready, 1);
    chk("arst_wr_en", rf_wr_en, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_en", rf_rd_en, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_xer", {xer_so, xer_ov}, 0);
    chk("arst_cr0", cr0, 0);
    m_ov = 1'b0;
    m_so = 1'b0;
    m_cr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("arst_idle_no_wr", rf_wr_en, 0);
      chk("arst_idle_ready", instr_ready, 1);
    end

    // Back-to-back with instr_valid held high
    regs[11] = {$urandom, $urandom};
    regs[12] = {$urandom, $urandom};
    regs[14] = {$urandom, $urandom};
    regs[15] = {$urandom, $urandom};
    iw  = mk(6'd31, 5'd10, 5'd11, 5'd12, 1'b0, 9'd266, 1'b0);
    iwb = mk(6'd31, 5'd13, 5'd14, 5'd15, 1'b0, 9'd40, 1'b0);
    ref_op(iw[9:1], regs[11], regs[12], ra_exp, ova);
    ref_op(iwb[9:1], regs[14], regs[15], rb_exp, ovb);
    @(negedge clk);
    chk("b2b_ready0", instr_ready, 1);
    instr       = iw;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = iwb;
    chk("b2b_rd_a", rf_ra_addr, 11);
    chk("b2b_busy1", instr_ready, 0);
    @(negedge clk);
    chk("b2b_busy2", instr_ready, 0);
    @(negedge clk);
    chk("b2b_done_a", done, 1);
    chk("b2b_data_a", rf_wr_data, ra_exp);
    chk("b2b_busy3", instr_ready, 0);
    model_wb(iw, ra_exp, ova);
    @(negedge clk);
    chk("b2b_ready4", instr_ready, 1);
    chk("b2b_no_rd4", rf_rd_en, 0);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b_rd_b", rf_rd_en, 1);
    chk("b2b_ra_b", rf_ra_addr, 14);
    chk("b2b_busy5", instr_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done_b", done, 1);
    chk("b2b_addr_b", rf_wr_addr, 13);
    chk("b2b_data_b", rf_wr_data, rb_exp);
    model_wb(iwb, rb_exp, ovb);
    @(negedge clk);
    chk("b2b_ready_end", instr_ready, 1);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      logic [5:0] po;
      logic [8:0] xo;
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) regs[$urandom_range(0, 31)] = 64'h7FFF_FFFF_FFFF_FFFF;
      else if (k == 1) regs[$urandom_range(0, 31)] = 64'h8000_0000_0000_0000;
      else if (k == 2) regs[$urandom_range(0, 31)] = '0;
      else regs[$urandom_range(0, 31)] = {$urandom, $urandom};
      po = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd31;
      k  = $urandom_range(0, 4);
      xo = (k == 4) ? 9'($urandom_range(0, 511)) : xo_tab[k];
      run(mk(po, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), xo,
             1'($urandom_range(0, 1))));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xo_exec_ctrl.md
Name: xo_exec_ctrl

Overview:
- Multi-cycle sequencer for uPower XO-format integer instructions (PO=31).
- Accepts one 32-bit instruction per valid/ready handshake, then decodes it into RT/RA/RB/OE/XO/Rc.
- Drives register-file read, ALU operand/op select and register-file write-back.
- Maintains XER[OV,SO] and CR0; sits between the instruction source and the existing register file / ALU datapath.

Parameters:
- ALU_LAT, 1, EXEC cycles for add/subf/neg (>=1)
- MUL_LAT, 4, EXEC cycles for mulld (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word: PO=[31:26], RT=[25:21], RA=[20:16], RB=[15:11], OE=[10], XO=[9:1], Rc=[0]
- instr_ready  out  1  controller can accept
- rf_rd_en  out  1  register-file read strobe
- rf_ra_addr  out  5  read port A address
- rf_rb_addr  out  5  read port B address
- rf_ra_data  in  64  port A data, valid cycle after rf_rd_en
- rf_rb_data  in  64  port B data, valid cycle after rf_rd_en
- alu_op  out  2  operation select
- alu_a  out  64  ALU operand A
- alu_b  out  64  ALU operand B
- alu_result  in  64  ALU result
- alu_ov  in  1  signed overflow of alu_result
- rf_wr_en  out  1  write-back strobe
- rf_wr_addr  out  5  write-back address
- rf_wr_data  out  64  write-back data
- xer_ov  out  1  XER overflow
- xer_so  out  1  XER summary overflow, sticky
- cr0  out  4  {LT,GT,EQ,SO}
- done  out  1  one-cycle pulse, legal instruction retired
- illegal  out  1  one-cycle pulse, instruction rejected

Behaviour:
- Reset: state IDLE; all outputs 0 except instr_ready=1. Reset mid-operation aborts with no write.
- Supported XO values; alu_op encoding ADD=0, SUBF=1, NEG=2, MUL=3:
  - 266 add: RT=RA+RB
  - 40 subf: RT=RB-RA
  - 104 neg: RT=-RA, RB ignored
  - 233 mulld: RT=low 64 bits of RA*RB, signed
- All arithmetic is 64-bit two's complement; the ALU computes it and the controller only selects.
- Operand mapping: alu_a=RA data, alu_b=RB data. The ALU applies the subf/neg semantics.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr and decode.
  - PO!=31 or XO unsupported: go to ERR. Otherwise go to READ.
- ERR (1 cycle): illegal=1, no rf/XER/CR change, then IDLE.
- READ (1 cycle): rf_rd_en=1, rf_ra_addr=RA, rf_rb_addr=RB.
- EXEC:
  - First cycle registers rf_ra_data/rf_rb_data into alu_a/alu_b; operands are held for the whole of EXEC.
  - Down-counter loaded with ALU_LAT or MUL_LAT; leave EXEC when it expires.
  - alu_result/alu_ov are sampled on the last EXEC cycle.
- WB (1 cycle):
  - rf_wr_en=1, rf_wr_addr=RT, rf_wr_data=sampled result; done=1.
  - If OE=1: xer_ov<=alu_ov and xer_so<=xer_so|alu_ov. If OE=0: XER unchanged.
  - If Rc=1: cr0<={res<0, res>0, res==0, updated xer_so}, signed. If Rc=0: cr0 unchanged.
  - XER, CR0 and the rf write all update at the end of WB. Next state IDLE.
- Latency from the accepting edge: READ 1 cycle, EXEC LAT cycles, WB 1 cycle. done is high in cycle 2+LAT (cycle 3 for ALU_LAT=1).
- Throughput: one instruction per 3+LAT cycles. Accept happens only in IDLE.
- instr_ready=0 in all states except IDLE; instr/instr_valid changes while busy are ignored.
- RT equal to RA or RB is legal: operands are latched before WB.
- Address 0 is an ordinary register, not a literal zero.
- done and illegal are never high together; rf_wr_en is high only in WB.

Decomposition:
- Package xo_pkg holds:
  - XO constants XO_ADD=9'd266, XO_SUBF=9'd40, XO_NEG=9'd104, XO_MULLD=9'd233
  - PO_XO=6'd31
  - alu_op codes
  - state enum IDLE/READ/EXEC/WB/ERR
- Sub-module xo_decode (combinational): instr -> rt/ra/rb/oe/rc, alu_op, legal, is_mul.
- The FSM, counter and XER/CR0 registers live in xo_exec_ctrl.

Test Plan:
- ADD R7,R2,R6, OE=0, Rc=0, R2=5, R6=10, ALU_LAT=1 -> rf_wr_en with addr 7, data 15 and done in cycle 3; XER and CR0 stay 0.
- subf R7,R3,R9, Rc=1, R3=4, R9=20 -> data 16, cr0=4'b0100; then subf with R3=20, R9=4 -> data -16, cr0=4'b1000.
- addo. with RA=64'h7FFF_FFFF_FFFF_FFFF, RB=1 -> data 64'h8000_0000_0000_0000, xer_ov=1, xer_so=1, cr0=4'b1001. Follow with addo 1+1 -> xer_ov=0, xer_so stays 1.
- PO=6'd14, or PO=31 with XO=9'd7 -> illegal pulse in cycle 1 after accept; no rf_rd_en/rf_wr_en; XER/CR0 unchanged; instr_ready back to 1 in cycle 2.
- mulld R1,R2,R3, MUL_LAT=4, R2=-3, R3=7 -> data -21 with done in cycle 6. Repeat with rst_n low in cycle 3 -> no rf_wr_en, all outputs 0, instr_ready=1 after release.
- Back-to-back with instr_valid held high -> second accept exactly one cycle after the first done; instr_ready low throughout READ/EXEC/WB.
